// File: rtl/memory_bus_controller_pkg.sv
// Shared constants for the core's bus side: timestate names, bus FSM encoding
// and the read data returned when an access is aborted.
package memory_bus_controller_pkg;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, ADDRESS, INSTRUCTION
    } cpu_timestate_t;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'd0,
        BUS_ACCESS   = 2'd1,
        BUS_COMPLETE = 2'd2
    } bus_state_t;

    localparam int          CNT_W            = 8;
    localparam logic [7:0]  ERR_DATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/memory_bus_controller_bus_timeout_counter.sv
// Cycle counter for an outstanding memory access; tc flags the last cycle
// the controller may wait for mem_ack before aborting.
module memory_bus_controller_bus_timeout_counter
    import memory_bus_controller_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low reset listed in the sensitivity list.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/memory_bus_controller.sv
// Runs one req/ack memory access per core timestate and pulses enableFFs for a
// single cycle when it retires; an unanswered access is aborted with a sticky error.
module memory_bus_controller
    import memory_bus_controller_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_valid,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              rdy,
    input  logic              err_clr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              enableFFs,
    output logic              bus_error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    bus_state_t state;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_tc;

    assign cnt_clr = (state == BUS_IDLE);
    assign cnt_en  = (state == BUS_ACCESS) && !mem_ack && !cnt_tc;

    memory_bus_controller_bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timeout_counter (
        .clk  (clk),
        .nrst (nrst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= BUS_IDLE;
            mem_req   <= 1'b0;
            enableFFs <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            bus_error <= 1'b0;
        end else begin
            // A timeout assignment later in this block overrides this clear.
            if (err_clr) begin
                bus_error <= 1'b0;
            end

            case (state)
                BUS_IDLE: begin
                    if (cpu_valid && rdy) begin
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_we    <= ~cpu_rw;
                        mem_req   <= 1'b1;
                        state     <= BUS_ACCESS;
                    end
                end

                BUS_ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                        mem_req   <= 1'b0;
                        enableFFs <= 1'b1;
                        state     <= BUS_COMPLETE;
                    end else if (cnt_tc) begin
                        bus_error <= 1'b1;
                        if (!mem_we) begin
                            cpu_rdata <= ERR_DATA;
                        end
                        mem_req   <= 1'b0;
                        enableFFs <= 1'b1;
                        state     <= BUS_COMPLETE;
                    end
                end

                BUS_COMPLETE: begin
                    enableFFs <= 1'b0;
                    state     <= BUS_IDLE;
                end

                default: begin
                    mem_req   <= 1'b0;
                    enableFFs <= 1'b0;
                    state     <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed bench for memory_bus_controller: reads, writes, timeout abort,
// rdy gating and asynchronous reset mid-access.
module tb_memory_bus_controller;

    logic        clk = 1'b0;
    logic        nrst;
    logic        cpu_valid;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        rdy;
    logic        err_clr;
    logic [7:0]  cpu_rdata;
    logic        enableFFs;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int n_req;

    memory_bus_controller #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .TIMEOUT  (16),
        .ERR_DATA (8'hFF)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cpu_valid (cpu_valid),
        .cpu_rw    (cpu_rw),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .rdy       (rdy),
        .err_clr   (err_clr),
        .cpu_rdata (cpu_rdata),
        .enableFFs (enableFFs),
        .bus_error (bus_error),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " mem_req"},   32'(mem_req),   0);
        check({tag, " enableFFs"}, 32'(enableFFs), 0);
    endtask

    initial begin
        nrst      = 1'b0;
        cpu_valid = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        rdy       = 1'b1;
        err_clr   = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state
        #12;
        check("rst mem_req",   32'(mem_req),   0);
        check("rst enableFFs", 32'(enableFFs), 0);
        check("rst bus_error", 32'(bus_error), 0);
        check("rst mem_we",    32'(mem_we),    0);
        check("rst mem_addr",  32'(mem_addr),  0);
        check("rst mem_wdata", 32'(mem_wdata), 0);
        check("rst cpu_rdata", 32'(cpu_rdata), 0);
        nrst = 1'b1;
        tick();
        check_idle("post-rst");

        // Read 0x1234, ack in the first request cycle
        cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h1234;
        tick();
        cpu_valid = 1'b0;
        check("rd1 mem_req",  32'(mem_req),  1);
        check("rd1 mem_we",   32'(mem_we),   0);
        check("rd1 mem_addr", 32'(mem_addr), 'h1234);
        check("rd1 en early", 32'(enableFFs), 0);
        mem_ack = 1'b1; mem_rdata = 8'hA9;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("rd1 req drop",  32'(mem_req),   0);
        check("rd1 enableFFs", 32'(enableFFs), 1);
        check("rd1 cpu_rdata", 32'(cpu_rdata), 'hA9);
        tick();
        check_idle("rd1 retire");

        // Write 0x5C to 0x0200, ack on the 4th request cycle; rdy drop mid-access
        cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 8'h5C;
        tick();
        cpu_valid = 1'b0; cpu_wdata = 8'h00; rdy = 1'b0;
        check("wr mem_req c1",   32'(mem_req),   1);
        check("wr mem_we",       32'(mem_we),    1);
        check("wr mem_addr",     32'(mem_addr),  'h0200);
        check("wr mem_wdata c1", 32'(mem_wdata), 'h5C);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("wr mem_req c%0d", i),   32'(mem_req),   1);
            check($sformatf("wr mem_wdata c%0d", i), 32'(mem_wdata), 'h5C);
            check($sformatf("wr en c%0d", i),        32'(enableFFs), 0);
        end
        rdy = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        check("wr enableFFs", 32'(enableFFs), 1);
        check("wr cpu_rdata", 32'(cpu_rdata), 'hA9);
        tick();
        check_idle("wr retire");

        // Read with no ack: abort after 16 request cycles
        cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4000;
        tick();
        cpu_valid = 1'b0;
        n_req = 0;
        while (mem_req === 1'b1 && n_req < 40) begin
            n_req++;
            tick();
        end
        check("to req cycles", 32'(n_req),     16);
        check("to enableFFs",  32'(enableFFs), 1);
        check("to cpu_rdata",  32'(cpu_rdata), 'hFF);
        check("to bus_error",  32'(bus_error), 1);
        tick();
        check("to en once",    32'(enableFFs), 0);
        check("to err sticky", 32'(bus_error), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 32'(bus_error), 0);

        // Ack arriving on the 16th request cycle completes normally
        cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4001;
        tick();
        cpu_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("ack16 req c16", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        check("ack16 enableFFs", 32'(enableFFs), 1);
        check("ack16 cpu_rdata", 32'(cpu_rdata), 'h3C);
        check("ack16 bus_error", 32'(bus_error), 0);
        tick();

        // Timeout and err_clr in the same cycle: the set wins
        cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4002;
        tick();
        cpu_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("setwin enableFFs", 32'(enableFFs), 1);
        check("setwin bus_error", 32'(bus_error), 1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("setwin clr", 32'(bus_error), 0);

        // rdy low blocks the start of an access
        rdy = 1'b0; cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0042;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rdy0 mem_req c%0d", i), 32'(mem_req), 0);
        end
        rdy = 1'b1;
        tick();
        cpu_valid = 1'b0;
        check("rdy1 mem_req",  32'(mem_req),  1);
        check("rdy1 mem_addr", 32'(mem_addr), 'h0042);

        // Asynchronous reset mid-access, then a stray ack while idle
        tick();
        #2 nrst = 1'b0;
        #1;
        check("arst mem_req",   32'(mem_req),   0);
        check("arst enableFFs", 32'(enableFFs), 0);
        check("arst mem_addr",  32'(mem_addr),  0);
        check("arst cpu_rdata", 32'(cpu_rdata), 0);
        tick();
        nrst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_idle($sformatf("stray c%0d", i));
            check($sformatf("stray rdata c%0d", i), 32'(cpu_rdata), 0);
        end
        mem_ack = 1'b0;
        check("stray bus_error", 32'(bus_error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
- Bus-side counterpart to the CPU timing/instruction state machine.
- The core presents one memory access per timestate. This block runs a req/ack handshake with external memory.
- It returns read data and drives the core's enableFFs stall input, pulsing it high for exactly one cycle when the access completes.
- Sits between the core datapath/state machine and the external memory/peripheral bus. Includes a timeout abort with a sticky error flag.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width
- TIMEOUT, 16, max cycles in ACCESS without mem_ack before abort (legal range 2..255)
- ERR_DATA, 8'hFF, read data returned on timeout abort

Ports:
- clk  input  1  clock
- nrst  input  1  asynchronous active-low reset
- cpu_valid  input  1  core presents an access this timestate
- cpu_rw  input  1  1=read, 0=write
- cpu_addr  input  ADDR_W  access address
- cpu_wdata  input  DATA_W  write data
- rdy  input  1  external RDY; low blocks starting a new access
- err_clr  input  1  clears bus_error
- cpu_rdata  output  DATA_W  registered read data to core
- enableFFs  output  1  one-cycle completion pulse to core state machine
- bus_error  output  1  sticky timeout flag
- mem_req  output  1  request to memory
- mem_we  output  1  write enable (registered ~cpu_rw)
- mem_addr  output  ADDR_W  registered address
- mem_wdata  output  DATA_W  registered write data
- mem_ack  input  1  memory completion
- mem_rdata  input  DATA_W  memory read data, valid with mem_ack

Behaviour:
- Interface: clock clk; reset nrst, asynchronous, active-low.
- Reset values: state=IDLE, all outputs 0, timeout counter 0.
- All outputs are registered. enableFFs and mem_req are decoded from state; state is a flop.
- States: IDLE, ACCESS, COMPLETE.
- IDLE:
  - If cpu_valid & rdy: latch cpu_addr→mem_addr, cpu_wdata→mem_wdata, ~cpu_rw→mem_we; clear counter; go ACCESS.
  - Otherwise stay in IDLE. mem_req=0, enableFFs=0.
- ACCESS:
  - mem_req=1. mem_addr, mem_we and mem_wdata are held stable.
  - If mem_ack: if read, cpu_rdata<=mem_rdata; go COMPLETE.
  - Else if counter==TIMEOUT-1: bus_error<=1; if read, cpu_rdata<=ERR_DATA; go COMPLETE.
  - Else counter++.
  - mem_ack on the same cycle as the timeout: ack wins, no error.
- COMPLETE:
  - enableFFs=1 for exactly this one cycle; mem_req=0; go IDLE unconditionally.
  - cpu_valid is ignored in COMPLETE; it belongs to the retiring access.
- Latency: cpu_valid sampled at edge 0 gives mem_req high from cycle 1. If mem_ack is seen at cycle k (k≥1), enableFFs is high in cycle k+1. Minimum 3 cycles per access.
- Writes leave cpu_rdata unchanged.
- mem_ack outside ACCESS is ignored.
- rdy is sampled only in IDLE. Deasserting rdy mid-access does not abort.
- bus_error stays set until err_clr. If err_clr and a new timeout happen in the same cycle, set wins.
- Counter width is 8 bits; it never wraps because the abort fires at TIMEOUT-1.
- Reset mid-ACCESS returns to IDLE immediately with mem_req=0 and no enableFFs pulse.

Decomposition:
- Shared param file: state encoding constants (BUS_IDLE, BUS_ACCESS, BUS_COMPLETE) and the ERR_DATA default, alongside the existing T0..T6/ADDRESS/INSTRUCTION defines.
- One natural sub-module, bus_timeout_counter: clear and enable inputs, terminal-count output at TIMEOUT-1.

Test Plan:
- Reset, then read addr 16'h1234 with mem_ack one cycle after mem_req, mem_rdata=8'hA9 → mem_req high 1 cycle; enableFFs pulses in the next cycle; cpu_rdata=8'hA9; mem_we=0.
- Write 8'h5C to 16'h0200 with ack after 4 cycles → mem_we=1, mem_wdata=8'h5C held for all 4 req cycles; one enableFFs pulse; cpu_rdata unchanged.
- Read with no ack, TIMEOUT=16 → mem_req high exactly 16 cycles; then enableFFs pulse, cpu_rdata=8'hFF, bus_error=1; err_clr clears bus_error.
- mem_ack arriving on the 16th ACCESS cycle → normal completion, bus_error stays 0.
- rdy=0 with cpu_valid=1 for 5 cycles → no mem_req; mem_req rises the cycle after rdy goes to 1.
- nrst pulsed low mid-ACCESS; stray mem_ack while in IDLE → all outputs 0, no enableFFs pulse, state IDLE; the stray ack is ignored.
